// File: rtl/det_sched_pkg.sv
// det_sched_pkg: shared types and elaboration-time helpers for det_scheduler.
//   state_e        frame sequencer states
//   scaled_dim()   image dimension after downscaling to scale s (4/(4+s))
//   num_windows()  window positions along one axis at scale s
//   w_scale_f()    scale index width, never below 1 bit
//   w_dim_f()      coordinate width for an image dimension
package det_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int scaled_dim(input int d, input int s);
    return (d * 4) / (4 + s);
  endfunction

  function automatic int num_windows(input int d, input int f, input int s);
    return scaled_dim(d, s) - f + 1;
  endfunction

  function automatic int w_scale_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int w_dim_f(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/win_pos_counter.sv
// win_pos_counter: raster (x, y) window position counter with per-scale limits.
//   clk, rst     clock, async active-high reset
//   clr          return to (0,0); wins over adv
//   adv          step to the next window in raster order
//   nx_last      last x index for the current scale (NX_s-1)
//   ny_last      last y index for the current scale (NY_s-1)
//   x, y         current window position
//   last_window  current position is the final window of the scale
module win_pos_counter #(
  parameter int W_X = 6,
  parameter int W_Y = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  input  logic [W_X-1:0] nx_last,
  input  logic [W_Y-1:0] ny_last,
  output logic [W_X-1:0] x,
  output logic [W_Y-1:0] y,
  output logic           last_window
);

  logic [W_X-1:0] x_q, x_d;
  logic [W_Y-1:0] y_q, y_d;
  logic           x_end;

  assign x_end       = (x_q == nx_last);
  assign last_window = x_end && (y_q == ny_last);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_end) begin
        x_d = '0;
        // wrapping past the final row leaves the counter ready for the next scale
        y_d = last_window ? '0 : y_q + W_Y'(1);
      end else begin
        x_d = x_q + W_X'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/det_scheduler.sv
// det_scheduler: frame-level sequencer for the detection pipeline.
// Issues one scale token per scale, walks the classifier result stream in
// raster order per scale and emits (x, y, scale) for every positive window.
//   start_valid/start_ready     frame start handshake (ready only in IDLE)
//   scale_valid/ready/data      scale configuration token to the fetcher
//   result_valid/ready/data     per-window classifier result (1 = positive)
//   det_valid/ready/x/y/scale   detection record, single-entry output register
//   busy                        frame in progress
//   done                        one-cycle pulse once the frame has drained
// Optional build macro DET_SCHED_COUNT_EN adds det_count[15:0], a saturating
// count of positive windows in the current frame, cleared on start.
module det_scheduler
  import det_sched_pkg::*;
#(
  parameter int  IMG_WIDTH      = 45,
  parameter int  IMG_HEIGHT     = 45,
  parameter int  FEATURE_WIDTH  = 25,
  parameter int  FEATURE_HEIGHT = 25,
  parameter int  SCALE_NUM      = 1,
  localparam int W_SCALE        = w_scale_f(SCALE_NUM),
  localparam int W_X            = w_dim_f(IMG_WIDTH),
  localparam int W_Y            = w_dim_f(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  output logic               scale_valid,
  input  logic               scale_ready,
  output logic [W_SCALE-1:0] scale_data,
  input  logic               result_valid,
  output logic               result_ready,
  input  logic               result_data,
  output logic               det_valid,
  input  logic               det_ready,
  output logic [W_X-1:0]     det_x,
  output logic [W_Y-1:0]     det_y,
  output logic [W_SCALE-1:0] det_scale,
  output logic               busy,
  output logic               done
`ifdef DET_SCHED_COUNT_EN
  ,
  output logic [15:0]        det_count
`endif
);

  localparam logic [W_SCALE-1:0] S_LAST = W_SCALE'(SCALE_NUM - 1);

  // per-scale window limits, constant tables indexed by the scale counter
  logic [SCALE_NUM-1:0][W_X-1:0] nx_tab;
  logic [SCALE_NUM-1:0][W_Y-1:0] ny_tab;

  for (genvar g = 0; g < SCALE_NUM; g++) begin : g_scale
    if (scaled_dim(IMG_WIDTH, g) < FEATURE_WIDTH ||
        scaled_dim(IMG_HEIGHT, g) < FEATURE_HEIGHT) begin : g_bad
      $fatal(1, "det_scheduler: scale %0d smaller than the feature window", g);
    end
    assign nx_tab[g] = W_X'(num_windows(IMG_WIDTH, FEATURE_WIDTH, g) - 1);
    assign ny_tab[g] = W_Y'(num_windows(IMG_HEIGHT, FEATURE_HEIGHT, g) - 1);
  end

  state_e             state_q, state_d;
  logic [W_SCALE-1:0] s_q, s_d;
  logic               start_ready_q, start_ready_d;
  logic               scale_valid_q, scale_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               det_valid_q, det_valid_d;
  logic [W_X-1:0]     det_x_q, det_x_d;
  logic [W_Y-1:0]     det_y_q, det_y_d;
  logic [W_SCALE-1:0] det_scale_q, det_scale_d;

  logic               start_hs, res_hs;
  logic               pos_clr, pos_adv, last_window;
  logic [W_X-1:0]     pos_x;
  logic [W_Y-1:0]     pos_y;

  assign start_hs     = start_valid && start_ready_q;
  // a result is taken only if the output register is free or draining this cycle
  assign result_ready = (state_q == RUN) && (!det_valid_q || det_ready);
  assign res_hs       = result_valid && result_ready;

  win_pos_counter #(
    .W_X (W_X),
    .W_Y (W_Y)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .clr         (pos_clr),
    .adv         (pos_adv),
    .nx_last     (nx_tab[s_q]),
    .ny_last     (ny_tab[s_q]),
    .x           (pos_x),
    .y           (pos_y),
    .last_window (last_window)
  );

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    det_valid_d = det_valid_q;
    det_x_d     = det_x_q;
    det_y_d     = det_y_q;
    det_scale_d = det_scale_q;
    pos_clr     = 1'b0;
    pos_adv     = 1'b0;

    if (det_ready) det_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_hs) begin
          s_d     = '0;
          busy_d  = 1'b1;
          pos_clr = 1'b1;
          state_d = CFG;
        end
      end
      CFG: begin
        if (scale_valid_q && scale_ready) state_d = RUN;
      end
      RUN: begin
        if (res_hs) begin
          pos_adv = 1'b1;
          if (result_data) begin
            // a new positive overrides a same-cycle drain of the register
            det_valid_d = 1'b1;
            det_x_d     = pos_x;
            det_y_d     = pos_y;
            det_scale_d = s_q;
          end
          if (last_window) begin
            if (s_q != S_LAST) begin
              s_d     = s_q + W_SCALE'(1);
              pos_clr = 1'b1;
              state_d = CFG;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (!det_valid_q || det_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    start_ready_d = (state_d == IDLE);
    scale_valid_d = (state_d == CFG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      s_q           <= '0;
      start_ready_q <= 1'b1;
      scale_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      det_valid_q   <= 1'b0;
      det_x_q       <= '0;
      det_y_q       <= '0;
      det_scale_q   <= '0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      start_ready_q <= start_ready_d;
      scale_valid_q <= scale_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      det_valid_q   <= det_valid_d;
      det_x_q       <= det_x_d;
      det_y_q       <= det_y_d;
      det_scale_q   <= det_scale_d;
    end
  end

  assign start_ready = start_ready_q;
  assign scale_valid = scale_valid_q;
  assign scale_data  = s_q;
  assign det_valid   = det_valid_q;
  assign det_x       = det_x_q;
  assign det_y       = det_y_q;
  assign det_scale   = det_scale_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef DET_SCHED_COUNT_EN
  logic [15:0] det_count_q, det_count_d;

  always_comb begin
    det_count_d = det_count_q;
    if (start_hs)
      det_count_d = '0;
    else if (res_hs && result_data && det_count_q != 16'hFFFF)
      det_count_d = det_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_count_q <= '0;
    else     det_count_q <= det_count_d;
  end

  assign det_count = det_count_q;
`endif

endmodule

// File: tb/tb_det_scheduler.sv
// Bench for det_scheduler with two scales (45x45 -> 21x21 windows, 36x36 -> 12x12).
module tb_det_scheduler;

  localparam int SCALE_NUM = 2;
  localparam int TOTAL     = 441 + 144;
  localparam int NPOS      = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0, scale_ready = 1'b0, result_valid = 1'b0;
  logic       result_data = 1'b0, det_ready = 1'b1;
  logic       start_ready, scale_valid, result_ready, det_valid, busy, done;
  logic [0:0] scale_data, det_scale;
  logic [5:0] det_x, det_y;
`ifdef DET_SCHED_COUNT_EN
  logic [15:0] det_count;
`endif

  det_scheduler #(
    .IMG_WIDTH(45), .IMG_HEIGHT(45), .FEATURE_WIDTH(25), .FEATURE_HEIGHT(25),
    .SCALE_NUM(SCALE_NUM)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .scale_valid(scale_valid), .scale_ready(scale_ready), .scale_data(scale_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .det_valid(det_valid), .det_ready(det_ready),
    .det_x(det_x), .det_y(det_y), .det_scale(det_scale),
    .busy(busy), .done(done)
`ifdef DET_SCHED_COUNT_EN
    , .det_count(det_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;   // global result index in the frame (scale 1 starts at 441)
    int ex;
    int ey;
    int es;
  } vec_t;

  typedef struct {
    int x;
    int y;
    int s;
  } det_t;

  vec_t tbl[NPOS];
  det_t det_q[$];
  int   chks = 0, errs = 0, done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit is_pos(input int g);
    for (int i = 0; i < NPOS; i++) if (tbl[i].g == g) return 1'b1;
    return 1'b0;
  endfunction

  // detection capture, done counting and hold-stability of det fields
  bit         hold_prev = 1'b0;
  logic [5:0] px, py;
  logic [0:0] ps;
  always @(negedge clk) begin
    #2;
    if (hold_prev && det_valid) begin
      check("det_x stable", 32'(det_x), 32'(px));
      check("det_y stable", 32'(det_y), 32'(py));
      check("det_scale stable", 32'(det_scale), 32'(ps));
    end
    hold_prev = det_valid && !det_ready;
    px = det_x; py = det_y; ps = det_scale;
    if (det_valid && det_ready) det_q.push_back('{int'(det_x), int'(det_y), int'(det_scale)});
    if (done) done_cnt++;
  end

  task automatic frame(input bit use_tbl, input int rst_at, input int stall_len,
                       input int cfg_hold, input bit keep_start);
    int g, last_cyc, tok, hold_cnt, stall_left, ndone0;
    bit stalled, done_seen;
    g = 0; last_cyc = 0; tok = 0; hold_cnt = 0; stall_left = 0;
    stalled = 0; done_seen = 0; ndone0 = done_cnt;
    det_q.delete();

    @(negedge clk); start_valid = 1'b1; #1;
    check("start_ready idle", 32'(start_ready), 1);
    @(negedge clk); start_valid = keep_start;

    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      if (stall_len > 0 && !stalled && det_valid) begin
        stalled = 1; stall_left = stall_len;
      end
      det_ready    = (stall_left == 0) && (g != rst_at);
      scale_ready  = !(scale_valid && hold_cnt < cfg_hold);
      result_valid = (g < TOTAL);
      result_data  = (use_tbl && is_pos(g)) || (rst_at >= 0 && g == rst_at - 1);
      #1;
      if (cyc == 0) begin
        check("scale_valid 1 cyc after start", 32'(scale_valid), 1);
        check("busy after start", 32'(busy), 1);
        check("start_ready while busy", 32'(start_ready), 0);
`ifdef DET_SCHED_COUNT_EN
        check("det_count cleared", 32'(det_count), 0);
`endif
      end
      if (g == rst_at) begin
        check("det pending before rst", 32'(det_valid), 1);
        rst = 1'b1; #1;
        check("rst start_ready", 32'(start_ready), 1);
        check("rst scale_valid", 32'(scale_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst det_valid", 32'(det_valid), 0);
        check("rst result_ready", 32'(result_ready), 0);
        @(negedge clk);
        rst = 1'b0; result_valid = 1'b0; det_ready = 1'b1; start_valid = 1'b0;
        @(negedge clk); #3;
        check("no done after rst", done_cnt, ndone0);
        return;
      end
      if (stall_left > 0) begin
        check("result_ready in det stall", 32'(result_ready), 0);
        stall_left--;
      end
      if (scale_valid && !scale_ready) begin
        check("scale_data held", 32'(scale_data), tok);
        check("result_ready in CFG", 32'(result_ready), 0);
        hold_cnt++;
      end
      if (scale_valid && scale_ready) begin
        check("scale token index", 32'(scale_data), tok);
        tok++; hold_cnt = 0;
      end
      if (done) begin
        done_seen = 1; start_valid = 1'b0;
        check("results at done", g, TOTAL);
        check("done latency", cyc - last_cyc, 2);
`ifdef DET_SCHED_COUNT_EN
        check("det_count at done", 32'(det_count), use_tbl ? NPOS : 0);
`endif
      end
      if (result_valid && result_ready) begin
        g++; last_cyc = cyc;
      end
      @(negedge clk);
    end

    check("done reached", 32'(done_seen), 1);
    #1;
    check("done one pulse", 32'(done), 0);
    check("busy after done", 32'(busy), 0);
    check("start_ready after done", 32'(start_ready), 1);
    check("scale tokens", tok, SCALE_NUM);
    check("det records", det_q.size(), use_tbl ? NPOS : 0);
    if (use_tbl)
      for (int i = 0; i < NPOS && i < det_q.size(); i++) begin
        check($sformatf("det[%0d].x", i), det_q[i].x, tbl[i].ex);
        check($sformatf("det[%0d].y", i), det_q[i].y, tbl[i].ey);
        check($sformatf("det[%0d].s", i), det_q[i].s, tbl[i].es);
      end
  endtask

  initial begin
    // positives in raster order; scale 0 is 21 wide, scale 1 is 12 wide
    tbl[0] = '{0,        0,  0,  0};
    tbl[1] = '{20,       20, 0,  0};
    tbl[2] = '{21,       0,  1,  0};
    tbl[3] = '{22,       1,  1,  0};
    tbl[4] = '{440,      20, 20, 0};
    tbl[5] = '{441 + 13, 1,  1,  1};
    tbl[6] = '{441 + 143, 11, 11, 1};

    @(negedge clk); @(negedge clk); #1;
    check("reset start_ready", 32'(start_ready), 1);
    check("reset scale_valid", 32'(scale_valid), 0);
    check("reset result_ready", 32'(result_ready), 0);
    check("reset det_valid", 32'(det_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    @(negedge clk); rst = 1'b0;

    frame(1'b0, -1, 0,  0, 1'b0);   // all negative
    frame(1'b1, -1, 0,  0, 1'b1);   // positives, start held high throughout
    frame(1'b1, -1, 10, 0, 1'b0);   // detection consumer stalls 10 cycles
    frame(1'b1, -1, 0,  5, 1'b0);   // fetcher holds scale_ready low 5 cycles
    frame(1'b1, 200, 0, 0, 1'b0);   // reset mid-frame with a detection pending
    frame(1'b1, -1, 0,  0, 1'b0);   // clean restart from (0,0,0)

    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end

endmodule

// File: doc/det_scheduler.md
Name: det_scheduler

Overview:
- Frame-level sequencer for the detection pipeline.
- Accepts a frame start and issues one scale-configuration token per scale to the data fetcher.
- Consumes the classifier's per-window result stream and tracks the (x, y, scale) of each window in raster order.
- Emits a detection record for every positive window, and signals done when the last window of the last scale has been classified.

Parameters:
- IMG_WIDTH, 45, source image width in pixels
- IMG_HEIGHT, 45, source image height in pixels
- FEATURE_WIDTH, 25, classifier window width
- FEATURE_HEIGHT, 25, classifier window height
- SCALE_NUM, 1, number of scales processed per frame (at least 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start_valid  in  1  frame start request
- start_ready  out  1  high only in IDLE
- scale_valid  out  1  scale config token valid
- scale_ready  in  1  fetcher accepts the token
- scale_data  out  W_SCALE  scale index, 0..SCALE_NUM-1
- result_valid  in  1  classifier result valid
- result_ready  out  1  result accepted
- result_data  in  1  1 = window passed all stages
- det_valid  out  1  detection record valid
- det_ready  in  1  detection consumer ready
- det_x  out  W_X  window left column, in scaled coordinates
- det_y  out  W_Y  window top row, in scaled coordinates
- det_scale  out  W_SCALE  scale index of the detection
- busy  out  1  high from start acceptance until done
- done  out  1  single-cycle pulse after the last result of the frame

Behaviour:
- Width rules:
  - W_SCALE = max(1, $clog2(SCALE_NUM)).
  - W_X = $clog2(IMG_WIDTH); W_Y = $clog2(IMG_HEIGHT).
- Scaled dimensions:
  - W_s = (IMG_WIDTH*4)/(4+s) and H_s = (IMG_HEIGHT*4)/(4+s), integer truncation, evaluated at elaboration.
  - Window counts per scale: NX_s = W_s-FEATURE_WIDTH+1, NY_s = H_s-FEATURE_HEIGHT+1.
  - An elaboration-time assertion fails if any scale s < SCALE_NUM gives W_s < FEATURE_WIDTH or H_s < FEATURE_HEIGHT.
- Reset values: all outputs 0 except start_ready = 1; FSM in IDLE; counters x, y, s cleared.
- FSM states:
  - IDLE: start_ready = 1. On start_valid & start_ready: clear x, y, s; set busy; go to CFG.
  - CFG: scale_valid = 1 and scale_data = s, held stable until scale_ready. On the handshake, go to RUN. result_ready = 0 in this state.
  - RUN: result_ready = !det_valid | det_ready (single-entry output register). On each result handshake:
    - If result_data = 1, load det_x = x, det_y = y, det_scale = s and set det_valid.
    - Advance x. On x = NX_s-1, wrap x to 0 and advance y.
    - On the last window (x = NX_s-1 and y = NY_s-1): if s < SCALE_NUM-1, increment s, clear x and y, go to CFG; otherwise go to DRAIN.
  - DRAIN: wait until det_valid = 0, or det_valid & det_ready in the same cycle. Then pulse done for 1 cycle, clear busy, go to IDLE.
- Detection register: det_valid clears on det_ready unless a new positive result is loaded in the same cycle, in which case it stays set with the new values. det fields are held stable while det_valid & !det_ready.
- Latency:
  - Result handshake to det_valid: 1 cycle.
  - Last result to done, with det_ready held high: 2 cycles.
  - start to scale_valid: 1 cycle.
- Simultaneous or out-of-state events:
  - start_valid outside IDLE is ignored.
  - result_valid in IDLE or CFG is not accepted (result_ready = 0).
- Reset asserted mid-frame: immediate return to IDLE. A pending detection is dropped and done is not pulsed.

Optional Feature:
- Macro DET_SCHED_COUNT_EN.
- When defined:
  - Adds output det_count (16 bits), cleared on start acceptance.
  - Increments on each positive result accepted; saturates at 16'hFFFF.
  - Value is stable from the done pulse until the next start.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package det_sched_pkg holds:
  - state enum (IDLE, CFG, RUN, DRAIN);
  - functions scaled_dim(d, s) and num_windows(d, f, s);
  - the W_SCALE/W_X/W_Y width helpers.
- One natural sub-module, win_pos_counter: x/y raster counter with per-scale limits, producing a last_window flag.

Test Plan:
- Defaults, SCALE_NUM=1, all results 0, det_ready=1 -> 1 scale token (scale_data=0); 441 results accepted; no det_valid; done pulses 2 cycles after the 441st result.
- SCALE_NUM=2, results 1 only at index 0, index 440, and scale-1 index 143 -> dets at (0,0,0), (20,20,0) and (11,11,1) (scale 1 is 36x36, giving 12x12 windows); 2 scale tokens issued.
- det_ready=0 for 10 cycles with a pending det -> result_ready = 0 during the stall; det fields stable; no results lost or duplicated.
- scale_ready held low 5 cycles in CFG -> scale_valid and scale_data stable; results not accepted until after the handshake.
- rst asserted at result 200 -> all outputs return to reset values immediately; the next start restarts at (0,0,0).
- DET_SCHED_COUNT_EN defined, 7 positive results in the frame -> det_count = 7 at done; reads 0 one cycle after the next start is accepted.
